// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - shared arithmetic op encodings
package full_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_add_cell.sv
// rtl/full_add_cell.sv - 1-bit combinational full-adder cell
module full_add_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ c;
  assign co = (x & y) | (y & c) | (x & c);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - registered ripple-carry adder/subtractor with carry, overflow and valid
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             out_valid
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_comb;
  logic             carry_comb;
  logic             ovf_comb;

  // Subtraction reuses the adder: a - b - cin == a + ~b + ~cin.
  assign is_sub   = (sub == OP_SUB);
  assign b_eff    = is_sub ? ~b : b;
  assign chain[0] = is_sub ? ~cin : cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_add_cell u_cell (
      .x  (a[i]),
      .y  (b_eff[i]),
      .c  (chain[i]),
      .s  (sum_comb[i]),
      .co (chain[i+1])
    );
  end

  // Borrow is the complement of the chain carry-out when subtracting.
  assign carry_comb = is_sub ? ~chain[WIDTH] : chain[WIDTH];

  if (WIDTH > 1) begin : g_ovf
    always_comb begin
      ovf_comb = 1'b0;
      if (is_sub)
        ovf_comb = (a[WIDTH-1] != b[WIDTH-1]) && (sum_comb[WIDTH-1] != a[WIDTH-1]);
      else
        ovf_comb = (a[WIDTH-1] == b[WIDTH-1]) && (sum_comb[WIDTH-1] != a[WIDTH-1]);
    end
  end else begin : g_no_ovf
    assign ovf_comb = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum      <= sum_comb;
        carry    <= carry_comb;
        overflow <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - directed self-checking bench for full_adder (WIDTH=4 and WIDTH=1)
module tb_full_adder;

  logic       clk;
  logic       rst_n;

  logic       v4, sub4, cin4;
  logic [3:0] a4, b4;
  logic [3:0] sum4;
  logic       carry4, ovf4, ov4;

  logic       v1, sub1, cin1;
  logic [0:0] a1, b1;
  logic [0:0] sum1;
  logic       carry1, ovf1, ov1;

  int n_checks;
  int n_errors;

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v4),
    .sub       (sub4),
    .a         (a4),
    .b         (b4),
    .cin       (cin4),
    .sum       (sum4),
    .carry     (carry4),
    .overflow  (ovf4),
    .out_valid (ov4)
  );

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v1),
    .sub       (sub1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .sum       (sum1),
    .carry     (carry1),
    .overflow  (ovf1),
    .out_valid (ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv4(input logic v, input logic s, input logic [3:0] a, input logic [3:0] b,
                      input logic c);
    v4 = v; sub4 = s; a4 = a; b4 = b; cin4 = c;
  endtask

  task automatic drv1(input logic v, input logic a, input logic b, input logic c);
    v1 = v; sub1 = 1'b0; a1 = a; b1 = b; cin1 = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string tag, input logic [3:0] s, input logic c, input logic o,
                      input logic ov);
    chk({tag, "_sum"}, 32'(sum4), 32'(s));
    chk({tag, "_carry"}, 32'(carry4), 32'(c));
    chk({tag, "_ovf"}, 32'(ovf4), 32'(o));
    chk({tag, "_valid"}, 32'(ov4), 32'(ov));
  endtask

  task automatic chk1(input string tag, input logic s, input logic c);
    chk({tag, "_sum"}, 32'(sum1), 32'(s));
    chk({tag, "_carry"}, 32'(carry1), 32'(c));
    chk({tag, "_ovf"}, 32'(ovf1), 32'd0);
    chk({tag, "_valid"}, 32'(ov1), 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    drv4(1'b1, 1'b0, 4'hF, 4'hF, 1'b1);
    drv1(1'b1, 1'b1, 1'b1, 1'b1);
    tick(); tick();
    chk4("reset4", 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset1_sum", 32'(sum1), 32'd0);
    chk("reset1_valid", 32'(ov1), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 plain full adder, WIDTH=4 add cases in parallel
    drv1(1'b1, 1'b0, 1'b0, 1'b0);
    drv4(1'b1, 1'b0, 4'b0111, 4'b0001, 1'b0);
    tick();
    chk1("w1_00", 1'b0, 1'b0);
    chk4("add_0111_0001", 4'b1000, 1'b0, 1'b1, 1'b1);

    drv1(1'b1, 1'b0, 1'b1, 1'b0);
    drv4(1'b1, 1'b0, 4'b1111, 4'b0001, 1'b0);
    tick();
    chk1("w1_01", 1'b1, 1'b0);
    chk4("add_1111_0001", 4'b0000, 1'b1, 1'b0, 1'b1);

    drv1(1'b1, 1'b1, 1'b1, 1'b0);
    drv4(1'b1, 1'b1, 4'b0000, 4'b0001, 1'b0);
    tick();
    chk1("w1_11", 1'b0, 1'b1);
    chk4("sub_0000_0001", 4'b1111, 1'b1, 1'b0, 1'b1);

    drv1(1'b1, 1'b1, 1'b1, 1'b1);
    drv4(1'b1, 1'b1, 4'b1000, 4'b0001, 1'b0);
    tick();
    chk1("w1_11c", 1'b1, 1'b1);
    chk4("sub_1000_0001", 4'b0111, 1'b0, 1'b1, 1'b1);

    drv1(1'b0, 1'b0, 1'b0, 1'b0);
    drv4(1'b1, 1'b1, 4'b0101, 4'b0011, 1'b1);
    tick();
    chk4("sub_0101_0011_c1", 4'b0001, 1'b0, 1'b0, 1'b1);
    chk("w1_hold_valid", 32'(ov1), 32'd0);
    chk("w1_hold_sum", 32'(sum1), 32'd1);

    // Latency and hold
    drv4(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    chk("idle_valid", 32'(ov4), 32'd0);
    drv4(1'b1, 1'b0, 4'b0011, 4'b0100, 1'b0);
    #1;
    chk("no_comb_path_sum", 32'(sum4), 32'b0001);
    tick();
    chk4("lat_0011_0100", 4'b0111, 1'b0, 1'b0, 1'b1);
    drv4(1'b0, 1'b0, 4'b1010, 4'b1100, 1'b1);
    tick();
    chk4("hold1", 4'b0111, 1'b0, 1'b0, 1'b0);
    drv4(1'b0, 1'b1, 4'b0001, 4'b1110, 1'b0);
    tick();
    chk4("hold2", 4'b0111, 1'b0, 1'b0, 1'b0);

    // Back-to-back
    drv4(1'b1, 1'b0, 4'b0010, 4'b0011, 1'b0);
    tick();
    chk4("b2b_0", 4'b0101, 1'b0, 1'b0, 1'b1);
    drv4(1'b1, 1'b0, 4'b1001, 4'b0111, 1'b0);
    tick();
    chk4("b2b_1", 4'b0000, 1'b1, 1'b0, 1'b1);
    drv4(1'b1, 1'b1, 4'b0110, 4'b1001, 1'b0);
    tick();
    chk4("b2b_2", 4'b1101, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset mid-stream
    drv4(1'b1, 1'b0, 4'b0111, 4'b0111, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk4("async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk4("rst_held", 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drv4(1'b1, 1'b0, 4'b0100, 4'b0100, 1'b1);
    tick();
    chk4("after_rst", 4'b1001, 1'b0, 1'b1, 1'b1);
    drv4(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    tick();
    chk("after_rst_drop_valid", 32'(ov4), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
